// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Derive divisors from the 50 MHz system clock with hp_for_hz().
package clk_div_pkg;

    localparam int unsigned CLK_IN_HZ     = 50_000_000;
    localparam int unsigned DIV_W_DEFAULT = 16;
    localparam int unsigned DEFAULT_HP    = 200;

    // Half-period in clk_in cycles for a target output frequency.
    function automatic int unsigned hp_for_hz(input int unsigned f_hz);
        return CLK_IN_HZ / (2 * f_hz);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisor, 50% clock and rise tick.
// A pending divisor is applied only at a phase boundary, or at once while the channel is disabled.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DEFAULT_HP = 200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             pend_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] pend_hp_q, pend_hp_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        pend_hp_d = pend_hp_q;
        pend_d    = pend_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;

        // Load and apply are exclusive: a load is only taken while nothing is pending.
        if (load_i && !pend_q) begin
            pend_hp_d = (div_i == '0) ? DIV_W'(1) : div_i;
            pend_d    = 1'b1;
        end

        if (!en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
                hp_d   = pend_hp_q;
                pend_d = 1'b0;
            end
        end else if (cnt_q == hp_q - DIV_W'(1)) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            if (pend_q) begin
                hp_d   = pend_hp_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            hp_q      <= DIV_W'(DEFAULT_HP);
            pend_hp_q <= DIV_W'(DEFAULT_HP);
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            pend_hp_q <= pend_hp_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign pend_o = pend_q;
    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// CH independent programmable clock dividers with rise ticks off the 50 MHz system clock.
// Config writes go to a one-deep pending slot per channel; cfg_ready reflects the addressed slot.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CH         = 4,
    parameter int unsigned DIV_W      = clk_div_pkg::DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_HP = clk_div_pkg::DEFAULT_HP,
    localparam int unsigned CH_W      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_in_i,
    input  logic             rst_i,
    input  logic [CH-1:0]    en_i,
    input  logic             cfg_valid_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic [CH-1:0]    clk_out_o,
    output logic [CH-1:0]    tick_o
);

    logic [CH-1:0] pend;
    logic [CH-1:0] load;

    // Addresses beyond CH match no channel: ready stays high and the write is dropped.
    always_comb begin
        cfg_ready_o = 1'b1;
        load        = '0;
        for (int i = 0; i < CH; i++) begin
            if (cfg_ch_i == CH_W'(i)) begin
                cfg_ready_o = !pend[i];
                load[i]     = cfg_valid_i && !pend[i];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W      (DIV_W),
            .DEFAULT_HP (DEFAULT_HP)
        ) u_chan (
            .clk_i  (clk_in_i),
            .rst_i  (rst_i),
            .en_i   (en_i[g]),
            .load_i (load[g]),
            .div_i  (cfg_div_i),
            .pend_o (pend[g]),
            .clk_o  (clk_out_o[g]),
            .tick_o (tick_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (CH=4, default half-period 200).
// k counts enabled clock edges since reset release; checks are taken 1 ns after each edge.
module tb_clk_div_multi;

    logic        clk_in_i = 1'b0;
    logic        rst_i;
    logic [3:0]  en_i;
    logic        cfg_valid_i;
    logic [1:0]  cfg_ch_i;
    logic [15:0] cfg_div_i;
    logic        cfg_ready_o;
    logic [3:0]  clk_out_o;
    logic [3:0]  tick_o;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_multi #(.CH(4), .DIV_W(16), .DEFAULT_HP(200)) dut (
        .clk_in_i    (clk_in_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_ready_o (cfg_ready_o),
        .clk_out_o   (clk_out_o),
        .tick_o      (tick_o)
    );

    always #5 clk_in_i = ~clk_in_i;

    task automatic step(input int n);
        repeat (n) @(posedge clk_in_i);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; en_i = 4'b1111; cfg_valid_i = 1'b0; cfg_ch_i = 2'd0; cfg_div_i = 16'd0;
        step(1);
        chk4("rst_clk", clk_out_o, 4'b0000);
        chk4("rst_tick", tick_o, 4'b0000);
        chk1("rst_ready", cfg_ready_o, 1'b1);
        step(1);
        rst_i = 1'b0;

        // Defaults: rise at k200, fall k400, rise k600
        step(199); chk4("k199_clk", clk_out_o, 4'b0000);
        step(1);   chk4("k200_clk", clk_out_o, 4'b1111);
                   chk4("k200_tick", tick_o, 4'b1111);
        step(199); chk4("k399_clk", clk_out_o, 4'b1111);
        step(1);   chk4("k400_clk", clk_out_o, 4'b0000);
                   chk4("k400_tick", tick_o, 4'b0000);
        step(199); chk4("k599_clk", clk_out_o, 4'b0000);
        step(1);   chk4("k600_clk", clk_out_o, 4'b1111);
                   chk4("k600_tick", tick_o, 4'b1111);
        step(1);   chk4("k601_tick", tick_o, 4'b0000);

        // ch1 <- 5 mid-phase (cnt=50); applied at the k800 fall
        step(49);
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_div_i = 16'd5;
        chk1("ch1_ready_pre", cfg_ready_o, 1'b1);
        step(1);
        cfg_valid_i = 1'b0;
        chk1("ch1_ready_pend", cfg_ready_o, 1'b0);
        step(148); chk4("k799_clk", clk_out_o, 4'b1111);
                   chk1("k799_ready", cfg_ready_o, 1'b0);
        step(1);   chk4("k800_clk", clk_out_o, 4'b0000);
                   chk1("k800_ready", cfg_ready_o, 1'b1);
        step(4);   chk4("k804_clk", clk_out_o, 4'b0000);
        step(1);   chk4("k805_clk", clk_out_o, 4'b0010);
                   chk4("k805_tick", tick_o, 4'b0010);
        step(1);   chk4("k806_tick", tick_o, 4'b0000);
        step(4);   chk4("k810_clk", clk_out_o, 4'b0000);
        step(5);   chk4("k815_clk", clk_out_o, 4'b0010);
                   chk4("k815_tick", tick_o, 4'b0010);

        // ch2 <- 10 then 20 back to back; second write stalls until k1000
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd2; cfg_div_i = 16'd10;
        chk1("ch2_ready_first", cfg_ready_o, 1'b1);
        step(1);
        cfg_div_i = 16'd20;
        chk1("ch2_ready_stall", cfg_ready_o, 1'b0);
        step(183); chk1("k999_ready", cfg_ready_o, 1'b0);
                   chk1("k999_clk2", clk_out_o[2], 1'b0);
        step(1);   chk4("k1000_clk", clk_out_o, 4'b1101);
                   chk4("k1000_tick", tick_o, 4'b1101);
                   chk1("k1000_ready", cfg_ready_o, 1'b1);
        step(1);
        cfg_valid_i = 1'b0;
        chk1("k1001_ready", cfg_ready_o, 1'b0);
        chk4("k1001_tick", tick_o, 4'b0000);
        step(8);   chk1("k1009_clk2", clk_out_o[2], 1'b1);
        step(1);   chk1("k1010_clk2", clk_out_o[2], 1'b0);
                   chk1("k1010_ready", cfg_ready_o, 1'b1);
        step(19);  chk1("k1029_clk2", clk_out_o[2], 1'b0);
        step(1);   chk1("k1030_clk2", clk_out_o[2], 1'b1);
                   chk1("k1030_tick2", tick_o[2], 1'b1);

        // ch0 <- 0, stored as 1: toggles every cycle after the k1200 fall
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 16'd0;
        chk1("ch0_ready", cfg_ready_o, 1'b1);
        step(1);
        cfg_valid_i = 1'b0;
        step(168); chk1("k1199_clk0", clk_out_o[0], 1'b1);
        step(1);   chk1("k1200_clk0", clk_out_o[0], 1'b0);
        step(1);   chk1("k1201_clk0", clk_out_o[0], 1'b1);
                   chk1("k1201_tick0", tick_o[0], 1'b1);
        step(1);   chk1("k1202_clk0", clk_out_o[0], 1'b0);
                   chk1("k1202_tick0", tick_o[0], 1'b0);
        step(1);   chk1("k1203_clk0", clk_out_o[0], 1'b1);
                   chk1("k1203_tick0", tick_o[0], 1'b1);

        // ch3 disabled while high, re-enabled: rise exactly 200 edges later
        step(197); chk1("k1400_clk3", clk_out_o[3], 1'b1);
                   chk1("k1400_tick3", tick_o[3], 1'b1);
        step(10);  chk1("k1410_clk3", clk_out_o[3], 1'b1);
        en_i = 4'b0111;
        step(1);   chk1("dis_clk3", clk_out_o[3], 1'b0);
                   chk1("dis_tick3", tick_o[3], 1'b0);
        step(5);   chk1("dis_hold_clk3", clk_out_o[3], 1'b0);
        en_i = 4'b1111;
        step(199); chk1("reen199_clk3", clk_out_o[3], 1'b0);
        step(1);   chk1("reen200_clk3", clk_out_o[3], 1'b1);
                   chk1("reen200_tick3", tick_o[3], 1'b1);

        // Reset with ch0 pending: pending divisor must be discarded
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_div_i = 16'd7;
        chk1("pend_ready_pre", cfg_ready_o, 1'b1);
        step(1);
        cfg_valid_i = 1'b0;
        chk1("pend_ready_set", cfg_ready_o, 1'b0);
        rst_i = 1'b1;
        step(1);   chk1("rst2_ready", cfg_ready_o, 1'b1);
                   chk4("rst2_clk", clk_out_o, 4'b0000);
                   chk4("rst2_tick", tick_o, 4'b0000);
        step(1);
        rst_i = 1'b0;
        step(199); chk4("r199_clk", clk_out_o, 4'b0000);
                   chk1("r199_ready", cfg_ready_o, 1'b1);
        step(1);   chk4("r200_clk", clk_out_o, 4'b1111);
                   chk4("r200_tick", tick_o, 4'b1111);
        step(7);   chk1("r207_clk0", clk_out_o[0], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
